// File: rtl/i2s_mem_feeder_pkg.sv
// Shared widths, buffer count and FSM state encoding for the I2S memory feeder.
package i2s_mem_feeder_pkg;

   localparam int unsigned DefAddrWidth = 32;
   localparam int unsigned DefSizeWidth = 24;
   localparam int unsigned NumBufs      = 2;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StRead   = 3'd1,
      StStrobe = 3'd2,
      StFinish = 3'd3,
      StHold   = 3'd4
   } feed_state_e;

endpackage

// File: rtl/i2s_buffer_slot.sv
// One host-armed audio buffer: base, size, read offset and armed flag.
// last_o flags that the word at the current offset is the final one.
module i2s_buffer_slot
   import i2s_mem_feeder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned SIZE_WIDTH = DefSizeWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  go_i,
   input  logic [ADDR_WIDTH-1:0] base_i,
   input  logic [SIZE_WIDTH-1:0] size_i,
   input  logic                  advance_i,
   input  logic                  clear_i,
   output logic [ADDR_WIDTH-1:0] base_o,
   output logic [SIZE_WIDTH-1:0] offset_o,
   output logic                  valid_o,
   output logic                  last_o
);

   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic [SIZE_WIDTH-1:0] offset_q, offset_d;
   logic                  valid_q, valid_d;
   logic                  last_w;
   logic                  release_w;
   logic                  arm_w;

   assign last_w    = valid_q && ((offset_q + SIZE_WIDTH'(1)) == size_q);
   assign release_w = advance_i && last_w;
   // A buffer being released this cycle may be re-armed in the same cycle.
   assign arm_w     = go_i && (size_i != '0) && (!valid_q || release_w) && !clear_i;

   // Next-state: advance, release on last word, arm, and disarm on clear.
   always_comb begin
      base_d   = base_q;
      size_d   = size_q;
      offset_d = offset_q;
      valid_d  = valid_q;
      if (advance_i && valid_q) begin
         offset_d = offset_q + SIZE_WIDTH'(1);
      end
      if (release_w) begin
         valid_d = 1'b0;
      end
      if (arm_w) begin
         base_d   = base_i;
         size_d   = size_i;
         offset_d = '0;
         valid_d  = 1'b1;
      end
      if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   // Slot registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base_q   <= '0;
         size_q   <= '0;
         offset_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         base_q   <= base_d;
         size_q   <= size_d;
         offset_q <= offset_d;
         valid_q  <= valid_d;
      end
   end

   assign base_o   = base_q;
   assign offset_o = offset_q;
   assign valid_o  = valid_q;
   assign last_o   = last_w;

endmodule

// File: rtl/i2s_mem_feeder.sv
// Feeds 32-bit words from a ping-pong pair of armed buffers to the I2S
// controller through a single-word read port. Every output is a flop.
module i2s_mem_feeder
   import i2s_mem_feeder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned SIZE_WIDTH = DefSizeWidth
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] buf_base [NumBufs],
   input  logic [SIZE_WIDTH-1:0] buf_size [NumBufs],
   input  logic [NumBufs-1:0]    buf_go,
   output logic [NumBufs-1:0]    buf_done,
   output logic [NumBufs-1:0]    buf_valid,
   output logic                  active_buf,
   output logic                  underrun,
   input  logic                  request_data,
   input  logic [SIZE_WIDTH-1:0] request_size,
   output logic                  request_finished,
   output logic [31:0]           memory_data,
   output logic                  memory_data_strobe,
   output logic                  mem_rd_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_rd_ack,
   input  logic [31:0]           mem_rd_data
);

   feed_state_e           state_q, state_d;
   logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;
   logic                  active_q, active_d;
   logic                  rd_req_q, rd_req_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           data_q, data_d;
   logic                  strobe_q, strobe_d;
   logic                  finished_q, finished_d;
   logic                  underrun_q, underrun_d;
   logic [NumBufs-1:0]    done_q, done_d;
   logic                  abort_q, abort_d;

   logic [ADDR_WIDTH-1:0] slot_base   [NumBufs];
   logic [SIZE_WIDTH-1:0] slot_offset [NumBufs];
   logic [NumBufs-1:0]    slot_valid;
   logic [NumBufs-1:0]    slot_last;
   logic                  advance_w;
   logic                  clear_w;
   logic                  abort_now;
   logic                  act_valid;
   logic                  act_last;
   logic [ADDR_WIDTH-1:0] act_addr;

   for (genvar i = 0; i < NumBufs; i++) begin : g_slot
      i2s_buffer_slot #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .SIZE_WIDTH (SIZE_WIDTH)
      ) u_slot (
         .clk_i     (clk),
         .rst_ni    (rst),
         .go_i      (buf_go[i]),
         .base_i    (buf_base[i]),
         .size_i    (buf_size[i]),
         .advance_i (advance_w && (active_q == 1'(i))),
         .clear_i   (clear_w),
         .base_o    (slot_base[i]),
         .offset_o  (slot_offset[i]),
         .valid_o   (slot_valid[i]),
         .last_o    (slot_last[i])
      );
   end

   assign act_valid = slot_valid[active_q];
   assign act_last  = slot_last[active_q];
   // Byte address of the next word; wraps modulo 2^ADDR_WIDTH.
   assign act_addr  = slot_base[active_q] + ADDR_WIDTH'({slot_offset[active_q], 2'b00});

   // Next-state and next-output logic; enable-low abort overrides everything.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      active_d    = active_q;
      rd_req_d    = rd_req_q;
      addr_d      = addr_q;
      data_d      = data_q;
      strobe_d    = 1'b0;
      finished_d  = 1'b0;
      underrun_d  = 1'b0;
      done_d      = '0;
      advance_w   = 1'b0;
      clear_w     = 1'b0;
      // An outstanding read must complete before the abort can take effect.
      abort_d     = rd_req_q && !mem_rd_ack && (abort_q || !enable);
      abort_now   = (abort_q || !enable) && !(rd_req_q && !mem_rd_ack);

      unique case (state_q)
         StIdle: begin
            if (request_data && enable) begin
               remaining_d = request_size;
               if (request_size == '0) begin
                  state_d    = StFinish;
                  finished_d = 1'b1;
               end else begin
                  // Entering READ without a valid buffer is the underrun path.
                  state_d    = StRead;
                  rd_req_d   = act_valid;
                  underrun_d = !act_valid;
                  if (act_valid) begin
                     addr_d = act_addr;
                  end
               end
            end
         end
         StRead: begin
            if (!rd_req_q) begin
               state_d    = StFinish;
               finished_d = 1'b1;
            end else if (mem_rd_ack) begin
               rd_req_d    = 1'b0;
               data_d      = mem_rd_data;
               advance_w   = 1'b1;
               remaining_d = remaining_q - SIZE_WIDTH'(1);
               strobe_d    = 1'b1;
               state_d     = StStrobe;
               // Release happens here so buf_done lines up with the strobe.
               if (act_last) begin
                  done_d[active_q] = 1'b1;
                  active_d         = !active_q;
               end
            end
         end
         StStrobe: begin
            if (remaining_q == '0) begin
               state_d    = StFinish;
               finished_d = 1'b1;
            end else begin
               state_d    = StRead;
               rd_req_d   = act_valid;
               underrun_d = !act_valid;
               if (act_valid) begin
                  addr_d = act_addr;
               end
            end
         end
         StFinish: begin
            state_d = StHold;
         end
         StHold: begin
            if (!request_data) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (abort_now) begin
         state_d     = StIdle;
         remaining_d = '0;
         active_d    = 1'b0;
         rd_req_d    = 1'b0;
         data_d      = data_q;
         strobe_d    = 1'b0;
         finished_d  = 1'b0;
         underrun_d  = 1'b0;
         done_d      = '0;
         advance_w   = 1'b0;
         clear_w     = 1'b1;
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         active_q    <= 1'b0;
         rd_req_q    <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         strobe_q    <= 1'b0;
         finished_q  <= 1'b0;
         underrun_q  <= 1'b0;
         done_q      <= '0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         active_q    <= active_d;
         rd_req_q    <= rd_req_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         strobe_q    <= strobe_d;
         finished_q  <= finished_d;
         underrun_q  <= underrun_d;
         done_q      <= done_d;
         abort_q     <= abort_d;
      end
   end

   assign buf_done           = done_q;
   assign buf_valid          = slot_valid;
   assign active_buf         = active_q;
   assign underrun           = underrun_q;
   assign request_finished   = finished_q;
   assign memory_data        = data_q;
   assign memory_data_strobe = strobe_q;
   assign mem_rd_req         = rd_req_q;
   assign mem_addr           = addr_q;

endmodule

// File: tb/tb_i2s_mem_feeder.sv
// Scoreboard bench: the driver predicts strobe/underrun/finish events from a
// buffer-level model; a monitor pops and compares as the DUT emits them.
module tb_i2s_mem_feeder;

   localparam int EvStrobe = 1;
   localparam int EvUnder  = 2;
   localparam int EvFinish = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [31:0] buf_base [2];
   logic [23:0] buf_size [2];
   logic [1:0]  buf_go;
   logic [1:0]  buf_done;
   logic [1:0]  buf_valid;
   logic        active_buf;
   logic        underrun;
   logic        request_data;
   logic [23:0] request_size;
   logic        request_finished;
   logic [31:0] memory_data;
   logic        memory_data_strobe;
   logic        mem_rd_req;
   logic [31:0] mem_addr;
   logic        mem_rd_ack;
   logic [31:0] mem_rd_data;

   typedef struct {
      int         kind;
      logic [31:0] addr;
      logic [1:0]  done;
      int         prev;
   } ev_t;

   ev_t         exp_q [$];
   int          strobe_cyc [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_kind = 0;
   int          fixed_lat = -1;
   int          wait_left = -1;
   logic [31:0] req_addr;
   logic [31:0] last_ack_addr = '0;

   // Buffer-level reference model.
   bit          m_valid [2];
   logic [31:0] m_base [2];
   int unsigned m_size [2];
   int unsigned m_off [2];
   bit          m_active;

   i2s_mem_feeder dut (
      .clk                (clk),
      .rst                (rst),
      .enable             (enable),
      .buf_base           (buf_base),
      .buf_size           (buf_size),
      .buf_go             (buf_go),
      .buf_done           (buf_done),
      .buf_valid          (buf_valid),
      .active_buf         (active_buf),
      .underrun           (underrun),
      .request_data       (request_data),
      .request_size       (request_size),
      .request_finished   (request_finished),
      .memory_data        (memory_data),
      .memory_data_strobe (memory_data_strobe),
      .mem_rd_req         (mem_rd_req),
      .mem_addr           (mem_addr),
      .mem_rd_ack         (mem_rd_ack),
      .mem_rd_data        (mem_rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_valid[i] = 1'b0;
         m_off[i]   = 0;
      end
      m_active = 1'b0;
   endtask

   // Memory responder: acks after a fixed or random wait, data derived from address.
   initial begin
      mem_rd_ack  = 1'b0;
      mem_rd_data = '0;
      forever begin
         @(negedge clk);
         mem_rd_ack = 1'b0;
         if (!rst) begin
            wait_left = -1;
         end else if (mem_rd_req) begin
            if (wait_left < 0) begin
               wait_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
               req_addr  = mem_addr;
            end else begin
               check("addr_stable", mem_addr, req_addr);
            end
            if (wait_left == 0) begin
               mem_rd_ack    = 1'b1;
               mem_rd_data   = data_of(mem_addr);
               last_ack_addr = mem_addr;
               wait_left     = -1;
            end else begin
               wait_left--;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT emits an event.
   initial begin
      ev_t e;
      int  cur_kind;
      forever begin
         @(negedge clk);
         if (!rst) begin
            last_kind = 0;
         end else begin
            cyc++;
            cur_kind = 0;
            if (memory_data_strobe) begin
               cur_kind = 1;
               strobe_cyc.push_back(cyc);
               if (exp_q.size() == 0 || exp_q[0].kind != EvStrobe) begin
                  flag("strobe");
               end else begin
                  e = exp_q.pop_front();
                  check("strobe_addr", last_ack_addr, e.addr);
                  check("strobe_data", memory_data, data_of(e.addr));
                  check("buf_done", buf_done, e.done);
               end
            end else if (buf_done != 2'b00) begin
               flag("buf_done");
            end
            if (underrun) begin
               cur_kind = 2;
               if (exp_q.size() == 0 || exp_q[0].kind != EvUnder) flag("underrun");
               else e = exp_q.pop_front();
            end
            if (request_finished) begin
               if (exp_q.size() == 0 || exp_q[0].kind != EvFinish) begin
                  flag("request_finished");
               end else begin
                  e = exp_q.pop_front();
                  check("finish_timing", last_kind, e.prev);
               end
            end
            last_kind = cur_kind;
         end
      end
   end

   task automatic arm(input int n, input logic [31:0] base, input int unsigned size);
      @(negedge clk);
      buf_base[n] = base;
      buf_size[n] = 24'(size);
      buf_go      = 2'b00;
      buf_go[n]   = 1'b1;
      @(negedge clk);
      buf_go = 2'b00;
      if (size != 0 && !m_valid[n]) begin
         m_valid[n] = 1'b1;
         m_base[n]  = base;
         m_size[n]  = size;
         m_off[n]   = 0;
      end
   endtask

   task automatic do_request(input int unsigned n, input int unsigned hold);
      ev_t e;
      int  prev;
      int  a;
      int  c;
      int  extra;
      bit  first_valid;
      first_valid = m_valid[m_active];
      prev = 0;
      for (int k = 0; k < int'(n); k++) begin
         a = int'(m_active);
         if (!m_valid[a]) begin
            e.kind = EvUnder; e.addr = '0; e.done = '0; e.prev = 0;
            exp_q.push_back(e);
            prev = 2;
            break;
         end
         e.kind = EvStrobe;
         e.addr = m_base[a] + 32'(4 * m_off[a]);
         e.done = '0;
         e.prev = 0;
         m_off[a]++;
         if (m_off[a] == m_size[a]) begin
            e.done[a]  = 1'b1;
            m_valid[a] = 1'b0;
            m_active   = !m_active;
         end
         exp_q.push_back(e);
         prev = 1;
      end
      e.kind = EvFinish; e.addr = '0; e.done = '0; e.prev = prev;
      exp_q.push_back(e);

      @(negedge clk);
      request_size = 24'(n);
      request_data = 1'b1;
      @(negedge clk);
      if (n == 0) begin
         check("zero_finish_n1", request_finished, 1);
         check("zero_no_req", mem_rd_req, 0);
      end else if (first_valid) begin
         check("first_req_n1", mem_rd_req, 1);
      end else begin
         check("first_underrun_n1", underrun, 1);
      end
      c = 0;
      while (!request_finished && c < 400) begin
         @(negedge clk);
         c++;
      end
      if (!request_finished) begin
         flag("request_timeout");
         exp_q.delete();
      end
      if (hold > 0) begin
         extra = 0;
         for (int h = 0; h < int'(hold); h++) begin
            @(negedge clk);
            if (mem_rd_req) extra++;
         end
         check("hold_no_rerequest", extra, 0);
      end
      request_data = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("buf_valid", buf_valid, {m_valid[1], m_valid[0]});
      check("active_buf", active_buf, m_active);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b0;
      request_data = 1'b0;
      buf_go       = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      exp_q.delete();
   endtask

   task automatic random_phase();
      int          na;
      int          b;
      logic [31:0] base;
      for (int it = 0; it < 40; it++) begin
         na = $urandom_range(0, 2);
         for (int j = 0; j < na; j++) begin
            b    = $urandom_range(0, 1);
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            arm(b, base, $urandom_range(0, 5));
         end
         do_request($urandom_range(0, 9), $urandom_range(0, 3));
      end
   endtask

   task automatic abort_test();
      int  c;
      bit  acked;
      do_reset();
      arm(0, 32'h0000_3000, 4);
      fixed_lat = 5;
      @(negedge clk);
      request_size = 24'd2;
      request_data = 1'b1;
      @(negedge clk);
      #2;
      check("abort_req_up", mem_rd_req, 1);
      enable = 1'b0;
      acked  = 1'b0;
      c      = 0;
      while (!acked && c < 20) begin
         @(negedge clk);
         #2;
         if (mem_rd_ack) acked = 1'b1;
         else check("abort_req_held", mem_rd_req, 1);
         c++;
      end
      if (!acked) flag("abort_ack_timeout");
      @(negedge clk);
      #2;
      check("abort_outputs_quiet",
            {mem_rd_req, memory_data_strobe, request_finished, underrun, buf_done}, 0);
      check("abort_valid_cleared", buf_valid, 2'b00);
      check("abort_active_zero", active_buf, 0);
      request_data = 1'b0;
      fixed_lat    = -1;
      model_clear();
      @(negedge clk);
      enable = 1'b1;
      arm(0, 32'h0000_5000, 2);
      do_request(2, 0);
   endtask

   task automatic reset_test();
      arm(0, 32'h0000_6000, 3);
      arm(1, 32'h0000_7000, 3);
      fixed_lat = 30;
      @(negedge clk);
      request_size = 24'd3;
      request_data = 1'b1;
      @(negedge clk);
      #2;
      check("reset_pre_req", mem_rd_req, 1);
      rst = 1'b0;
      #1;
      check("reset_async_ctrl", {buf_done, buf_valid, active_buf, underrun, request_finished,
                                 memory_data_strobe, mem_rd_req}, 0);
      check("reset_async_data", {memory_data, mem_addr}, 0);
      request_data = 1'b0;
      exp_q.delete();
      model_clear();
      fixed_lat = -1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      enable       = 1'b1;
      buf_go       = 2'b00;
      buf_base[0]  = '0;
      buf_base[1]  = '0;
      buf_size[0]  = '0;
      buf_size[1]  = '0;
      request_data = 1'b0;
      request_size = '0;
      model_clear();
      repeat (3) @(negedge clk);
      check("reset_ctrl", {buf_done, buf_valid, active_buf, underrun, request_finished,
                           memory_data_strobe, mem_rd_req}, 0);
      check("reset_data", {memory_data, mem_addr}, 0);
      rst = 1'b1;

      // Single buffer, zero-wait memory: one word every two cycles.
      fixed_lat = 0;
      arm(0, 32'h0000_1000, 4);
      strobe_cyc.delete();
      do_request(4, 0);
      check("t1_strobe_count", strobe_cyc.size(), 4);
      for (int i = 1; i < 4 && i < strobe_cyc.size(); i++) begin
         check("t1_strobe_gap", strobe_cyc[i] - strobe_cyc[i-1], 2);
      end
      fixed_lat = -1;

      // Request spanning both buffers.
      do_reset();
      arm(0, 32'h0000_1000, 3);
      arm(1, 32'h0000_2000, 3);
      do_request(5, 0);
      do_request(1, 0);

      // Buffer runs dry mid-request.
      do_reset();
      arm(0, 32'h0000_1000, 2);
      do_request(4, 0);

      // Zero-size request held high: a single finish and no reads.
      do_request(0, 6);

      // Re-arming an already valid buffer and arming with size 0 are ignored.
      arm(1, 32'h0000_8000, 2);
      arm(1, 32'h0000_9000, 3);
      arm(0, 32'h0000_A000, 0);
      do_request(3, 0);

      random_phase();
      abort_test();
      reset_test();

      do_request(1, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
